// File: rtl/glonass_ca_gen_pkg.sv
// glonass_pkg: shared constants and the C/A LFSR next-state function.
//   CA_LEN         chips per code period
//   CA_INIT        LFSR load value (reset, sync, every code epoch)
//   CA_TAP         LFSR stage (1..9) driven onto the chip output
//   MS_PER_BIT     code epochs per navigation data bit
//   MS_PER_MEANDER code epochs per meander half-period
//   F_CHIP, F_CLK  nominal chip and system clock rates
package glonass_pkg;
    localparam int         CA_LEN         = 511;
    localparam logic [8:0] CA_INIT        = 9'h1FF;
    localparam int         CA_TAP         = 7;
    localparam int         MS_PER_BIT     = 20;
    localparam int         MS_PER_MEANDER = 10;
    localparam int         F_CHIP         = 511000;
    localparam int         F_CLK          = 5000000;

    // Bit k-1 holds stage s(k); G(X)=1+X^5+X^9 feeds s5^s9 into s1.
    function automatic logic [8:0] ca_next(input logic [8:0] s);
        return {s[7:0], s[4] ^ s[8]};
    endfunction
endpackage

// File: rtl/glonass_ca_gen_if.sv
// glonass_ca_if: chip-clock control inputs and C/A code / epoch outputs.
//   clk_511k, en, sync                      driven by master, read by slave
//   chip_stb, ca_chip, chip_idx, ca_epoch,
//   ms_cnt, meander, bit_epoch, lfsr_err    driven by slave (the generator)
interface glonass_ca_if;
    logic       clk_511k;
    logic       en;
    logic       sync;
    logic       chip_stb;
    logic       ca_chip;
    logic [8:0] chip_idx;
    logic       ca_epoch;
    logic [4:0] ms_cnt;
    logic       meander;
    logic       bit_epoch;
    logic       lfsr_err;

    modport master (
        output clk_511k, en, sync,
        input  chip_stb, ca_chip, chip_idx, ca_epoch, ms_cnt, meander, bit_epoch, lfsr_err
    );
    modport slave (
        input  clk_511k, en, sync,
        output chip_stb, ca_chip, chip_idx, ca_epoch, ms_cnt, meander, bit_epoch, lfsr_err
    );
endinterface

// File: rtl/glonass_ca_gen_lfsr.sv
// glonass_ca_lfsr: 9-stage C/A LFSR with load (priority) and advance.
//   clk, rst_n  system clock, async active-low reset (loads INIT)
//   load        force state to INIT
//   adv         step the LFSR once
//   state       current stages s1..s9 in bits 0..8
//   nxt         natural next state (used for wrap consistency checking)
module glonass_ca_lfsr
    import glonass_pkg::*;
#(
    parameter logic [8:0] INIT = CA_INIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       adv,
    output logic [8:0] state,
    output logic [8:0] nxt
);
    assign nxt = ca_next(state);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= INIT;
        else if (load)
            state <= INIT;
        else if (adv)
            state <= nxt;
    end
endmodule

// File: rtl/glonass_ca_gen.sv
// glonass_ca_gen: GLONASS C/A code generator clocked by 511 kHz chip-clock edges.
//   clk, rst_n  5 MHz system clock, async active-low reset
//   ca.clk_511k chip clock sampled as data; rising edges advance the code
//   ca.en       1 = accept chip edges, 0 = freeze (edges lost)
//   ca.sync     restart to chip 0 / ms 0 (wins over a same-cycle advance)
//   ca.chip_stb registered pulse per accepted chip edge
//   ca.ca_chip  current code chip; ca.chip_idx its index 0..CODE_LEN-1
//   ca.ca_epoch pulse when chip 0 becomes current
//   ca.ms_cnt   code epoch within data bit; ca.meander 10 ms meander level
//   ca.bit_epoch pulse with ca_epoch at data-bit start
//   ca.lfsr_err sticky: LFSR did not naturally return to LFSR_INIT at wrap
module glonass_ca_gen
    import glonass_pkg::*;
#(
    parameter int         CODE_LEN       = CA_LEN,
    parameter logic [8:0] LFSR_INIT      = CA_INIT,
    parameter int         OUT_TAP        = CA_TAP,
    parameter int         MS_PER_MEANDER = glonass_pkg::MS_PER_MEANDER,
    parameter int         MS_PER_BIT     = glonass_pkg::MS_PER_BIT
) (
    input  logic           clk,
    input  logic           rst_n,
    glonass_ca_if.slave    ca
);
    logic       prev;
    logic       armed;
    logic       edge_det;
    logic       wrap;
    logic [8:0] lfsr;
    logic [8:0] lfsr_nxt;
    logic [4:0] ms_nxt;

    // armed is set once clk_511k has been seen low after reset, so a chip
    // clock that is already high at reset release is not taken as an edge.
    assign edge_det   = ca.clk_511k & ~prev & armed;
    assign wrap       = ca.chip_stb && (ca.chip_idx == 9'(CODE_LEN - 1));
    assign ms_nxt     = (ca.ms_cnt == 5'(MS_PER_BIT - 1)) ? 5'd0 : ca.ms_cnt + 5'd1;
    assign ca.ca_chip = lfsr[OUT_TAP-1];

    glonass_ca_lfsr #(.INIT(LFSR_INIT)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (ca.sync | wrap),
        .adv   (ca.chip_stb),
        .state (lfsr),
        .nxt   (lfsr_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev         <= 1'b0;
            armed        <= 1'b0;
            ca.chip_stb  <= 1'b0;
            ca.chip_idx  <= '0;
            ca.ca_epoch  <= 1'b0;
            ca.ms_cnt    <= '0;
            ca.meander   <= 1'b0;
            ca.bit_epoch <= 1'b0;
            ca.lfsr_err  <= 1'b0;
        end else begin
            prev         <= ca.clk_511k;
            armed        <= armed | ~ca.clk_511k;
            ca.chip_stb  <= edge_det & ca.en;
            ca.ca_epoch  <= 1'b0;
            ca.bit_epoch <= 1'b0;
            if (ca.sync) begin
                ca.chip_idx  <= '0;
                ca.ms_cnt    <= '0;
                ca.meander   <= 1'b0;
                ca.ca_epoch  <= 1'b1;
                ca.bit_epoch <= 1'b1;
            end else if (wrap) begin
                ca.chip_idx  <= '0;
                ca.ms_cnt    <= ms_nxt;
                ca.ca_epoch  <= 1'b1;
                ca.bit_epoch <= (ms_nxt == 5'd0);
                if (ms_nxt == 5'd0 || ms_nxt == 5'(MS_PER_MEANDER))
                    ca.meander <= ~ca.meander;
                if (lfsr_nxt != LFSR_INIT)
                    ca.lfsr_err <= 1'b1;
            end else if (ca.chip_stb) begin
                ca.chip_idx <= ca.chip_idx + 9'd1;
            end
        end
    end
endmodule

// File: tb/tb_glonass_ca_gen.sv
// tb_glonass_ca_gen: directed, scoreboarded bench for glonass_ca_gen.
`timescale 1ns/1ps
module tb_glonass_ca_gen;
    import glonass_pkg::*;

    typedef struct { int idx; logic chip; } exp_t;
    typedef struct { logic be; int ms; logic mea; } ep_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    glonass_ca_if ca();

    glonass_ca_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ca    (ca)
    );

    always #100 clk = ~clk;

    exp_t        sbq[$];
    ep_t         epq[$];
    logic        code[0:CA_LEN-1];
    int          checks = 0;
    int          errors = 0;
    int          exp_idx = 0;
    int          pushes = 0;
    bit          mon_en = 1'b0;
    bit          cap = 1'b0;
    bit          pend = 1'b0;
    int          stb_cnt = 0;
    int          ones = 0;
    logic [10:0] first11 = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic push_exp();
        exp_idx = (exp_idx + 1) % CA_LEN;
        sbq.push_back('{exp_idx, code[exp_idx]});
        pushes++;
    endtask

    task automatic drive_edge();
        @(negedge clk);
        ca.clk_511k = 1'b1;
        if (ca.en) push_exp();
        @(negedge clk);
        ca.clk_511k = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    // Chip one cycle after each chip_stb must match the next scoreboard entry.
    always @(negedge clk) begin
        if (ca.chip_stb) stb_cnt <= stb_cnt + 1;
        if (ca.ca_epoch) epq.push_back('{ca.bit_epoch, int'(ca.ms_cnt), ca.meander});
        if (pend) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_empty observed=stb expected=none");
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("chip_idx", 32'(ca.chip_idx), e.idx);
                chk("ca_chip", 32'(ca.ca_chip), 32'(e.chip));
                if (ca.ca_chip) ones <= ones + 1;
                if (cap && e.idx <= 10) first11[10-e.idx] <= ca.ca_chip;
            end
        end
        pend <= mon_en && ca.chip_stb;
    end

    initial begin
        #(64'd200 * 90000);
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        logic a[0:CA_LEN+1];
        int   base, ep0, p0, idx0, d;
        logic c0;
        longint acc;
        logic nv;
        ep_t  e;

        // Independent code model: b[n]=b[n-5]^b[n-9], chip m = stage 7 = a[m+2].
        for (int i = 0; i < 9; i++) a[i] = 1'b1;
        for (int i = 9; i <= CA_LEN + 1; i++) a[i] = a[i-5] ^ a[i-9];
        for (int k = 0; k < CA_LEN; k++) code[k] = a[k+2];

        ca.en = 1'b1;
        ca.sync = 1'b0;
        ca.clk_511k = 1'b0;

        // Reset held while chip clock toggles.
        repeat (10) @(negedge clk) ca.clk_511k = ~ca.clk_511k;
        ca.clk_511k = 1'b1;
        @(negedge clk);
        chk("rst_stb_cnt", stb_cnt, 0);
        chk("rst_ca_chip", 32'(ca.ca_chip), 1);
        chk("rst_chip_idx", 32'(ca.chip_idx), 0);
        chk("rst_ms_cnt", 32'(ca.ms_cnt), 0);
        chk("rst_meander", 32'(ca.meander), 0);
        chk("rst_ca_epoch", 32'(ca.ca_epoch), 0);
        chk("rst_bit_epoch", 32'(ca.bit_epoch), 0);
        chk("rst_lfsr_err", 32'(ca.lfsr_err), 0);

        // Release with clk_511k high: no strobe until a fresh 0->1.
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("release_high_stb", stb_cnt, 0);
        ca.clk_511k = 1'b0;
        repeat (2) @(negedge clk);

        // One full code period.
        c0 = ca.ca_chip;
        chk("chip0", 32'(c0), 1);
        base = ones;
        cap = 1'b1;
        mon_en = 1'b1;
        repeat (CA_LEN - 1) drive_edge();
        settle();
        chk("no_early_epoch", epq.size(), 0);
        drive_edge();
        settle();
        cap = 1'b0;
        chk("first11", 32'(first11), 32'(11'b11111110000));
        chk("ones_per_period", ones - base, 256);
        chk("epoch_count", epq.size(), 1);
        chk("wrap_idx", 32'(ca.chip_idx), 0);
        chk("wrap_ms", 32'(ca.ms_cnt), 1);
        chk("lfsr_err_p1", 32'(ca.lfsr_err), 0);

        // 39 more periods: 40 ms of epochs in total.
        repeat ((MS_PER_BIT * 2 - 1) * CA_LEN) drive_edge();
        settle();
        chk("epochs_40", epq.size(), 40);
        for (int j = 0; j < 40 && j < epq.size(); j++) begin
            e = epq[j];
            chk($sformatf("ep%0d_ms", j), e.ms, (j + 1) % MS_PER_BIT);
            chk($sformatf("ep%0d_bit", j), 32'(e.be), 32'(((j + 1) % MS_PER_BIT) == 0));
            chk($sformatf("ep%0d_mea", j), 32'(e.mea), 32'(((j + 1) % MS_PER_BIT) >= MS_PER_MEANDER));
        end
        chk("lfsr_err_40", 32'(ca.lfsr_err), 0);
        epq.delete();

        // Freeze mid-code: edges while en=0 are lost.
        repeat (123) drive_edge();
        settle();
        ca.en = 1'b0;
        base = stb_cnt;
        repeat (50) drive_edge();
        settle();
        chk("frozen_idx", 32'(ca.chip_idx), 123);
        chk("frozen_stb", stb_cnt - base, 0);
        ca.en = 1'b1;
        settle();
        chk("no_replay_stb", stb_cnt - base, 0);
        chk("no_replay_idx", 32'(ca.chip_idx), 123);

        // Sync coincident with chip_stb at chip 300.
        repeat (177) drive_edge();
        settle();
        mon_en = 1'b0;
        @(negedge clk);
        ca.clk_511k = 1'b1;
        @(negedge clk);
        chk("sync_pre_idx", 32'(ca.chip_idx), 300);
        chk("sync_stb", 32'(ca.chip_stb), 1);
        ca.sync = 1'b1;
        ca.clk_511k = 1'b0;
        @(negedge clk);
        ca.sync = 1'b0;
        chk("sync_idx", 32'(ca.chip_idx), 0);
        chk("sync_chip", 32'(ca.ca_chip), 1);
        chk("sync_ca_epoch", 32'(ca.ca_epoch), 1);
        chk("sync_bit_epoch", 32'(ca.bit_epoch), 1);
        chk("sync_ms", 32'(ca.ms_cnt), 0);
        chk("sync_meander", 32'(ca.meander), 0);
        @(negedge clk);
        chk("sync_epoch_end", 32'(ca.ca_epoch), 0);
        chk("sync_no_adv", 32'(ca.chip_idx), 0);
        exp_idx = 0;
        epq.delete();
        mon_en = 1'b1;
        repeat (5) drive_edge();
        settle();

        // Rate: chip clock from a 511 kHz NCO against the 5 MHz system clock.
        base = stb_cnt;
        p0 = pushes;
        idx0 = exp_idx;
        ep0 = epq.size();
        acc = 0;
        repeat (10000) begin
            @(negedge clk);
            acc += F_CHIP;
            if (acc >= F_CLK) acc -= F_CLK;
            nv = (acc >= F_CLK / 2);
            if (nv && !ca.clk_511k && ca.en) push_exp();
            ca.clk_511k = nv;
        end
        @(negedge clk);
        ca.clk_511k = 1'b0;
        settle();
        d = stb_cnt - base;
        chk("rate_stb_range", 32'(d >= 1021 && d <= 1023), 1);
        chk("rate_stb_exact", d, pushes - p0);
        chk("rate_epochs", epq.size() - ep0, (idx0 + pushes - p0) / CA_LEN);

        // Async reset at ms 7, chip 200.
        @(negedge clk);
        ca.sync = 1'b1;
        @(negedge clk);
        ca.sync = 1'b0;
        exp_idx = 0;
        repeat (7 * CA_LEN + 200) drive_edge();
        settle();
        chk("pre_rst_ms", 32'(ca.ms_cnt), 7);
        chk("pre_rst_idx", 32'(ca.chip_idx), 200);
        chk("pre_rst_lfsr_err", 32'(ca.lfsr_err), 0);
        mon_en = 1'b0;
        @(negedge clk);
        #20;
        rst_n = 1'b0;
        #1;
        chk("arst_idx", 32'(ca.chip_idx), 0);
        chk("arst_ms", 32'(ca.ms_cnt), 0);
        chk("arst_chip", 32'(ca.ca_chip), 1);
        chk("arst_meander", 32'(ca.meander), 0);
        chk("arst_stb", 32'(ca.chip_stb), 0);
        chk("arst_epoch", 32'(ca.ca_epoch), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
